stream_demux_1to2_32: RTL and testbench
=======================================

// Module: stream_demux_1to2_32
// PURPOSE
//  Routes a 32-bit word stream from one producer to one of two consumers, selected per word.
//  It is the distribution counterpart of the 2:1 32-bit select path: one source, two sinks.
//  Each sink has its own small FIFO, so a stalled sink does not block words bound for the other.
//  It sits between the datapath result bus and two write-back/forwarding consumers.
// PARAMETERS
//  WIDTH  32  data width in bits.
//  DEPTH  2   entries per output FIFO; must be a power of two, >= 2.
//  CNTW   16  width of each per-output accepted-word counter.
// PORTS
//  clk         in   1      rising-edge clock; the only clock.
//  reset       in   1      synchronous reset, active-high.
//  in_data     in   WIDTH  word offered by the producer.
//  in_sel      in   1      destination: 0 -> out0, 1 -> out1; valid only with in_valid.
//  in_valid    in   1      producer offers in_data/in_sel this cycle.
//  in_ready    out  1      block accepts this cycle; combinational from in_sel and FIFO state.
//  out0_data   out  WIDTH  head word of FIFO0.
//  out0_valid  out  1      FIFO0 is not empty.
//  out0_ready  in   1      consumer 0 takes the head word this cycle.
//  out1_data   out  WIDTH  head word of FIFO1.
//  out1_valid  out  1      FIFO1 is not empty.
//  out1_ready  in   1      consumer 1 takes the head word this cycle.
//  out0_count  out  CNTW   words accepted for out0 since reset; wraps modulo 2^CNTW.
//  out1_count  out  CNTW   words accepted for out1 since reset; wraps modulo 2^CNTW.
// BEHAVIOUR
//  - Reset: synchronous, active-high; one asserted clk edge is enough.
//  - After reset: both FIFOs empty, outN_valid=0, outN_data=0, outN_count=0.
//  - Reset wins over any push or pop in the same cycle; all in-flight words are dropped.
//  - in_ready = in_sel ? !full1 : !full0, using registered occupancy only.
//  - in_ready never depends on out0_ready/out1_ready: no combinational ready path.
//  - A full FIFO refuses a push even if it pops in that cycle.
//  - Push: in_valid && in_ready pushes in_data into FIFO[in_sel] at the edge.
//  - Push: the same edge increments outN_count for the selected N.
//  - Pop: outN_valid && outN_ready removes the head word of FIFO N at the edge.
//  - Latency: a word accepted at edge k shows on outN_data/outN_valid after edge k, if FIFO N was empty.
//  - Push and pop on the same FIFO in one cycle: occupancy unchanged; order preserved.
//  - FIFO0 and FIFO1 run independently; both may pop in one cycle while the input pushes to either.
//  - Per-output order is strict FIFO. There is no ordering guarantee between out0 and out1.
//  - outN_data is held stable while outN_valid=1 and outN_ready=0.
//  - When FIFO N is empty, outN_data keeps the last storage value; do not check it.
//  - Pointers are log2(DEPTH) bits and wrap; occupancy is log2(DEPTH)+1 bits, range 0..DEPTH.
//  - Counter wrap: 2^CNTW-1 + 1 -> 0, with no flag.
//  - in_sel/in_data are ignored when in_valid=0; the producer may change them while not accepted.
// TESTING
//  1. Reset for 2 cycles, then idle.
//     -> in_ready=1 for both in_sel values; outN_valid=0, outN_data=0, counts=0.
//  2. Push 0xDEADBEEF with sel=0, out0_ready=1.
//     -> next cycle out0_valid=1 and out0_data=0xDEADBEEF; the following cycle out0_valid=0.
//     -> out0_count=1, out1_count=0.
//  3. Hold out1_ready=0. Push 0x11, 0x22 with sel=1, then offer 0x33 with sel=1.
//     -> in_ready=0 for sel=1.
//     -> Then offer 0x44 with sel=0: accepted; out0_data=0x44.
//  4. Release out1_ready. -> out1 yields 0x11 then 0x22, in order; 0x33 is accepted once FIFO1 has room.
//  5. FIFO0 full, push 0x55 with sel=0 while out0_ready=1. -> push refused that cycle; one pop; occupancy becomes 1.
//  6. Assert reset with both FIFOs holding data.
//     -> next cycle both valids=0 and counts=0; no stale word appears afterwards.
//  7. Set CNTW=4; push 16 words with sel=1. -> out1_count reads 15 after the 15th word, 0 after the 16th.

Source files
------------

// File: rtl/stream_demux_1to2_32.sv
// 1-to-2 word-stream demultiplexer: each word is routed to out0 or out1 by in_sel.
// Each output has its own FIFO, so a stalled consumer never blocks the other one.
module stream_demux_1to2_32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNTW-1:0]  out0_count,
  output logic [CNTW-1:0]  out1_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [1:0][DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [1:0][AW-1:0]               wptr_q, wptr_d;
  logic [1:0][AW-1:0]               rptr_q, rptr_d;
  logic [1:0][OW-1:0]               occ_q, occ_d;
  logic [1:0][CNTW-1:0]             cnt_q, cnt_d;
  logic [1:0]                       full, push, pop, out_ready;

  assign out_ready = {out1_ready, out0_ready};

  // Ready comes from registered occupancy only; a full FIFO refuses even while popping.
  always_comb begin
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    full     = '0;
    push     = '0;
    pop      = '0;
    in_ready = 1'b0;

    for (int n = 0; n < 2; n++) begin
      full[n] = (occ_q[n] == OW'(DEPTH));
    end
    in_ready = in_sel ? !full[1] : !full[0];

    for (int n = 0; n < 2; n++) begin
      push[n] = in_valid && in_ready && (in_sel == 1'(n));
      pop[n]  = (occ_q[n] != '0) && out_ready[n];
      if (push[n]) begin
        mem_d[n][wptr_q[n]] = in_data;
        wptr_d[n]           = wptr_q[n] + AW'(1);
        cnt_d[n]            = cnt_q[n] + CNTW'(1);
      end
      if (pop[n]) begin
        rptr_d[n] = rptr_q[n] + AW'(1);
      end
      case ({push[n], pop[n]})
        2'b10:   occ_d[n] = occ_q[n] + OW'(1);
        2'b01:   occ_d[n] = occ_q[n] - OW'(1);
        default: occ_d[n] = occ_q[n];
      endcase
    end
  end

  // Reset clears storage too, so outN_data reads 0 right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out0_data  = mem_q[0][rptr_q[0]];
  assign out1_data  = mem_q[1][rptr_q[1]];
  assign out0_valid = (occ_q[0] != '0);
  assign out1_valid = (occ_q[1] != '0);
  assign out0_count = cnt_q[0];
  assign out1_count = cnt_q[1];

endmodule

// File: tb/tb_stream_demux_1to2_32.sv
// Self-checking bench: directed vector table, randomized traffic against a queue model,
// and a counter-wrap sequence on a CNTW=4 instance.
module tb_stream_demux_1to2_32;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_sel, in_valid, in_ready;
  logic [31:0] in_data, out0_data, out1_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [15:0] out0_count, out1_count;

  logic        c4_reset, c4_sel, c4_valid, c4_ready;
  logic [31:0] c4_data, c4_o0_data, c4_o1_data;
  logic        c4_o0_valid, c4_o0_ready, c4_o1_valid, c4_o1_ready;
  logic [3:0]  c4_o0_count, c4_o1_count;

  stream_demux_1to2_32 dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out0_count(out0_count), .out1_count(out1_count)
  );

  stream_demux_1to2_32 #(.CNTW(4)) dut_c4 (
    .clk(clk), .reset(c4_reset), .in_data(c4_data), .in_sel(c4_sel),
    .in_valid(c4_valid), .in_ready(c4_ready),
    .out0_data(c4_o0_data), .out0_valid(c4_o0_valid), .out0_ready(c4_o0_ready),
    .out1_data(c4_o1_data), .out1_valid(c4_o1_valid), .out1_ready(c4_o1_ready),
    .out0_count(c4_o0_count), .out1_count(c4_o1_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs applied during a cycle; expectations describe the state seen before that cycle's edge.
  typedef struct {
    logic        rst, iv, sel;
    logic [31:0] data;
    logic        r0, r1;
    logic        chk, rdy, v0, cd0;
    logic [31:0] d0;
    logic        v1, cd1;
    logic [31:0] d1;
    logic [15:0] c0, c1;
  } vec_t;

  function automatic vec_t mk(input logic rst, iv, sel, input logic [31:0] data,
                              input logic r0, r1, c, rdy, v0, cd0, input logic [31:0] d0,
                              input logic v1, cd1, input logic [31:0] d1,
                              input logic [15:0] c0, c1);
    vec_t v;
    v.rst = rst; v.iv = iv; v.sel = sel; v.data = data; v.r0 = r0; v.r1 = r1;
    v.chk = c; v.rdy = rdy; v.v0 = v0; v.cd0 = cd0; v.d0 = d0;
    v.v1 = v1; v.cd1 = cd1; v.d1 = d1; v.c0 = c0; v.c1 = c1;
    return v;
  endfunction

  vec_t vecs[20];

  logic [31:0] q0[$], q1[$];
  logic [15:0] m0, m1;
  logic        e_rdy, p0, p1;

  initial begin
    //              rst iv sel data          r0 r1 chk rdy v0 cd0 d0            v1 cd1 d1     c0 c1
    vecs[0]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,        0, 0, 1, 1, 0, 1, 32'h0,        0, 1, 32'h0,  0, 0);
    vecs[2]  = mk(0, 0, 1, 32'h0,        0, 0, 1, 1, 0, 1, 32'h0,        0, 1, 32'h0,  0, 0);
    vecs[3]  = mk(0, 1, 0, 32'hDEADBEEF, 1, 0, 1, 1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,        1, 0, 1, 1, 1, 1, 32'hDEADBEEF, 0, 0, 32'h0,  1, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,        1, 0, 1, 1, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0);
    vecs[6]  = mk(0, 1, 1, 32'h11,       1, 0, 1, 1, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0);
    vecs[7]  = mk(0, 1, 1, 32'h22,       0, 0, 1, 1, 0, 0, 32'h0,        1, 1, 32'h11, 1, 1);
    vecs[8]  = mk(0, 1, 1, 32'h33,       0, 0, 1, 0, 0, 0, 32'h0,        1, 1, 32'h11, 1, 2);
    vecs[9]  = mk(0, 1, 0, 32'h44,       0, 0, 1, 1, 0, 0, 32'h0,        1, 1, 32'h11, 1, 2);
    vecs[10] = mk(0, 1, 1, 32'h33,       0, 1, 1, 0, 1, 1, 32'h44,       1, 1, 32'h11, 2, 2);
    vecs[11] = mk(0, 1, 1, 32'h33,       0, 1, 1, 1, 1, 1, 32'h44,       1, 1, 32'h22, 2, 2);
    vecs[12] = mk(0, 0, 1, 32'h0,        0, 1, 1, 1, 1, 1, 32'h44,       1, 1, 32'h33, 2, 3);
    vecs[13] = mk(0, 0, 0, 32'h0,        0, 1, 1, 1, 1, 1, 32'h44,       0, 0, 32'h0,  2, 3);
    vecs[14] = mk(0, 1, 0, 32'hA0,       0, 0, 1, 1, 1, 1, 32'h44,       0, 0, 32'h0,  2, 3);
    vecs[15] = mk(0, 1, 0, 32'h55,       1, 0, 1, 0, 1, 1, 32'h44,       0, 0, 32'h0,  3, 3);
    vecs[16] = mk(0, 1, 1, 32'h66,       0, 0, 1, 1, 1, 1, 32'hA0,       0, 0, 32'h0,  3, 3);
    vecs[17] = mk(1, 1, 0, 32'h77,       1, 1, 1, 1, 1, 1, 32'hA0,       1, 1, 32'h66, 3, 4);
    vecs[18] = mk(0, 0, 0, 32'h0,        1, 1, 1, 1, 0, 1, 32'h0,        0, 1, 32'h0,  0, 0);
    vecs[19] = mk(0, 0, 0, 32'h0,        1, 1, 1, 1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0);

    reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    c4_reset = 1'b1; c4_valid = 1'b0; c4_sel = 1'b0; c4_data = '0;
    c4_o0_ready = 1'b0; c4_o1_ready = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; in_valid = vecs[i].iv; in_sel = vecs[i].sel; in_data = vecs[i].data;
      out0_ready = vecs[i].r0; out1_ready = vecs[i].r1;
      #1;
      if (vecs[i].chk) begin
        chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
        chk($sformatf("row%0d out0_valid", i), 32'(out0_valid), 32'(vecs[i].v0));
        chk($sformatf("row%0d out1_valid", i), 32'(out1_valid), 32'(vecs[i].v1));
        chk($sformatf("row%0d out0_count", i), 32'(out0_count), 32'(vecs[i].c0));
        chk($sformatf("row%0d out1_count", i), 32'(out1_count), 32'(vecs[i].c1));
        if (vecs[i].cd0) chk($sformatf("row%0d out0_data", i), out0_data, vecs[i].d0);
        if (vecs[i].cd1) chk($sformatf("row%0d out1_data", i), out1_data, vecs[i].d1);
      end
    end

    // Randomized traffic; the model is two queues plus two word counters.
    q0.delete(); q1.delete(); m0 = '0; m1 = '0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 299) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = 1'($urandom);
      in_data    = $urandom;
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = 1'($urandom);
      #1;
      e_rdy = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      chk($sformatf("rnd%0d in_ready", t), 32'(in_ready), 32'(e_rdy));
      chk($sformatf("rnd%0d out0_valid", t), 32'(out0_valid), 32'(q0.size() != 0));
      chk($sformatf("rnd%0d out1_valid", t), 32'(out1_valid), 32'(q1.size() != 0));
      chk($sformatf("rnd%0d out0_count", t), 32'(out0_count), 32'(m0));
      chk($sformatf("rnd%0d out1_count", t), 32'(out1_count), 32'(m1));
      if (q0.size() != 0) chk($sformatf("rnd%0d out0_data", t), out0_data, q0[0]);
      if (q1.size() != 0) chk($sformatf("rnd%0d out1_data", t), out1_data, q1[0]);
      if (reset) begin
        q0.delete(); q1.delete(); m0 = '0; m1 = '0;
      end else begin
        p0 = (q0.size() != 0) && out0_ready;
        p1 = (q1.size() != 0) && out1_ready;
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (in_valid && e_rdy) begin
          if (in_sel) begin q1.push_back(in_data); m1 = m1 + 16'd1; end
          else        begin q0.push_back(in_data); m0 = m0 + 16'd1; end
        end
      end
    end

    // Counter wrap on the CNTW=4 instance: 15 after 15 words, 0 after 16.
    @(negedge clk);
    c4_reset = 1'b1;
    @(negedge clk);
    c4_reset = 1'b0; c4_valid = 1'b1; c4_sel = 1'b1; c4_o1_ready = 1'b1;
    #1 chk("c4 count after reset", 32'(c4_o1_count), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      c4_data = 32'(i);
      #1 chk($sformatf("c4 in_ready w%0d", i), 32'(c4_ready), 32'd1);
      @(negedge clk);
      #1;
      chk($sformatf("c4 out1_count w%0d", i), 32'(c4_o1_count), 32'(i % 16));
      chk($sformatf("c4 out1_data w%0d", i), c4_o1_data, 32'(i));
      chk($sformatf("c4 out0_count w%0d", i), 32'(c4_o0_count), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
